// File: rtl/fft_pkg.sv
// Shared constants, complex word type and bit-reversal helper for the 32-point FFT datapath.
package fft_pkg;
    localparam int N      = 32;
    localparam int LOG2N  = 5;
    localparam int DW     = 8;
    localparam int CPLX_W = 2 * DW;

    typedef logic [CPLX_W-1:0] cplx_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry bank of complex words: single write port, all slots exposed on a flat read bus.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [LOG2N-1:0]      wr_slot,
    input  cplx_t                 wr_data,
    output logic [N*CPLX_W-1:0]   rd_bus
);

    cplx_t mem_q [N];
    cplx_t mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_slot] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N; p++) begin
                mem_q[p] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int p = 0; p < N; p++) begin
            rd_bus[p*CPLX_W +: CPLX_W] = mem_q[p];
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: natural-order real samples in, bit-reversed complex frames out.
module fft_frame_loader
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_last,
    output logic                  frame_valid,
    output logic [N*CPLX_W-1:0]   frame_data,
    input  logic                  frame_ack,
    output logic                  frame_err,
    output logic [15:0]           frames_done
);

    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]       full_q, full_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frames_done_q, frames_done_d;

    logic             accept, consume, at_last, wr_en;
    logic [N*CPLX_W-1:0] bus0, bus1;

    assign s_ready     = !full_q[wr_sel_q];
    assign frame_valid = full_q[rd_sel_q];
    assign frame_data  = rd_sel_q ? bus1 : bus0;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

    assign accept  = s_valid && s_ready;
    assign consume = frame_valid && frame_ack;
    assign at_last = (wr_idx_q == IDX_LAST);

    always_comb begin
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        wr_idx_d      = wr_idx_q;
        full_d        = full_q;
        frame_err_d   = 1'b0;
        frames_done_d = frames_done_q;
        wr_en         = 1'b0;

        // Consume and completion always target different banks, so both may land together.
        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end

        if (accept) begin
            if (s_last != at_last) begin
                frame_err_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                wr_en = 1'b1;
                if (at_last) begin
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = !wr_sel_q;
                    wr_idx_d         = '0;
                    frames_done_d    = frames_done_q + 16'd1;
                end else begin
                    wr_idx_d = wr_idx_q + LOG2N'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            wr_idx_q      <= '0;
            full_q        <= '0;
            frame_err_q   <= 1'b0;
            frames_done_q <= '0;
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            wr_idx_q      <= wr_idx_d;
            full_q        <= full_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
        end
    end

    fft_frame_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en && !wr_sel_q),
        .wr_slot (bitrev(wr_idx_q)),
        .wr_data ({s_data, DW'(0)}),
        .rd_bus  (bus0)
    );

    fft_frame_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en && wr_sel_q),
        .wr_slot (bitrev(wr_idx_q)),
        .wr_data ({s_data, DW'(0)}),
        .rd_bus  (bus1)
    );

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: queue-based frame model checked every cycle plus directed literal checks.
module tb_fft_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         frame_valid;
    logic [511:0] frame_data;
    logic         frame_ack;
    logic         frame_err;
    logic [15:0]  frames_done;

    int tests = 0;
    int fails = 0;

    fft_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    // Model: samples collected for the frame being filled, and completed frames awaiting ack.
    typedef logic [7:0] frame_t [32];
    logic [7:0]  m_fill [$];
    frame_t      m_q [$];
    logic [15:0] m_done;
    logic        m_err;
    bit          started = 0;

    function automatic int rev5(input int p);
        int r = 0;
        for (int b = 0; b < 5; b++) r = r * 2 + ((p >> b) & 1);
        return r;
    endfunction

    initial begin
        frame_t f;
        bit ready, valid;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_fill.delete();
                m_q.delete();
                m_done = 16'd0;
                m_err  = 1'b0;
            end else begin
                m_err = 1'b0;
                ready = (m_q.size() < 2);
                valid = (m_q.size() > 0);
                if (frame_ack && valid) void'(m_q.pop_front());
                if (s_valid && ready) begin
                    if (s_last != (m_fill.size() == 31)) begin
                        m_err = 1'b1;
                        m_fill.delete();
                    end else begin
                        m_fill.push_back(s_data);
                        if (m_fill.size() == 32) begin
                            for (int i = 0; i < 32; i++) f[i] = m_fill[i];
                            m_q.push_back(f);
                            m_fill.delete();
                            m_done = m_done + 16'd1;
                        end
                    end
                end
            end
            started = 1;
        end
    end

    initial begin
        logic [511:0] exp_data;
        forever begin
            @(negedge clk);
            if (started) begin
                tests++;
                if (s_ready !== (m_q.size() < 2)) begin
                    fails++;
                    $display("FAIL model_s_ready: got %0b expected %0b at %0t", s_ready, (m_q.size() < 2), $time);
                end
                tests++;
                if (frame_valid !== (m_q.size() > 0)) begin
                    fails++;
                    $display("FAIL model_frame_valid: got %0b expected %0b at %0t", frame_valid, (m_q.size() > 0), $time);
                end
                tests++;
                if (frame_err !== m_err) begin
                    fails++;
                    $display("FAIL model_frame_err: got %0b expected %0b at %0t", frame_err, m_err, $time);
                end
                tests++;
                if (frames_done !== m_done) begin
                    fails++;
                    $display("FAIL model_frames_done: got %0d expected %0d at %0t", frames_done, m_done, $time);
                end
                if (m_q.size() > 0) begin
                    for (int p = 0; p < 32; p++) exp_data[p*16 +: 16] = {m_q[0][rev5(p)], 8'h00};
                    tests++;
                    if (frame_data !== exp_data) begin
                        fails++;
                        $display("FAIL model_frame_data: got %0h expected %0h at %0t", frame_data, exp_data, $time);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample is accepted, leaving s_valid high.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got s_ready 0 expected 1 within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        s_valid   = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d);
        for (int i = 0; i < 32; i++) send(d, i == 31);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_s_ready", {31'd0, s_ready}, 32'd1);
        check("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_frames_done", {16'd0, frames_done}, 32'd0);
        check("reset_frame_data_zero", {31'd0, (frame_data == '0)}, 32'd1);

        // Ramp 0x00..0x1F
        for (int i = 0; i < 32; i++) send(8'(i), i == 31);
        s_valid = 1'b0; s_last = 1'b0;
        check("ramp_valid_next_cycle", {31'd0, frame_valid}, 32'd1);
        check("ramp_slot0", {16'd0, frame_data[0*16 +: 16]}, 32'h0000);
        check("ramp_slot1", {16'd0, frame_data[1*16 +: 16]}, 32'h1000);
        check("ramp_slot16", {16'd0, frame_data[16*16 +: 16]}, 32'h0100);
        check("ramp_slot31", {16'd0, frame_data[31*16 +: 16]}, 32'h1F00);
        check("ramp_slot24", {16'd0, frame_data[24*16 +: 16]}, 32'h0300);
        check("ramp_frames_done", {16'd0, frames_done}, 32'd1);
        ack();
        idle(2);

        // Ping-pong stall
        send_frame(8'h11);
        send_frame(8'h22);
        check("stall_s_ready_low", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b1; s_data = 8'h33; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_held_s_ready", {31'd0, s_ready}, 32'd0);
        check("stall_A_slot0", {16'd0, frame_data[0*16 +: 16]}, 32'h1100);
        ack();
        check("stall_B_slot0", {16'd0, frame_data[0*16 +: 16]}, 32'h2200);
        check("stall_s_ready_back", {31'd0, s_ready}, 32'd1);
        ack();
        check("stall_all_acked", {31'd0, frame_valid}, 32'd0);
        check("stall_frames_done", {16'd0, frames_done}, 32'd3);
        idle(2);

        // Early s_last at sample index 9
        for (int i = 0; i < 10; i++) send(8'h5A, i == 9);
        s_valid = 1'b0; s_last = 1'b0;
        check("early_last_err", {31'd0, frame_err}, 32'd1);
        check("early_last_no_valid", {31'd0, frame_valid}, 32'd0);
        @(negedge clk);
        check("early_last_err_one_cycle", {31'd0, frame_err}, 32'd0);
        send_frame(8'h7F);
        for (int p = 0; p < 32; p++)
            check($sformatf("after_err_slot%0d", p), {16'd0, frame_data[p*16 +: 16]}, 32'h7F00);
        ack();
        idle(1);

        // Missing s_last on sample 31
        for (int i = 0; i < 32; i++) send(8'h44, 1'b0);
        s_valid = 1'b0;
        check("missing_last_err", {31'd0, frame_err}, 32'd1);
        check("missing_last_frames_done", {16'd0, frames_done}, 32'd4);
        check("missing_last_no_valid", {31'd0, frame_valid}, 32'd0);
        send_frame(8'h55);
        check("good_after_missing_valid", {31'd0, frame_valid}, 32'd1);
        check("good_after_missing_slot5", {16'd0, frame_data[5*16 +: 16]}, 32'h5500);
        check("good_after_missing_done", {16'd0, frames_done}, 32'd5);

        // Completion of bank 1 in the same cycle as ack of bank 0
        for (int i = 0; i < 31; i++) send(8'h66, 1'b0);
        s_data = 8'h66; s_last = 1'b1; s_valid = 1'b1; frame_ack = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; frame_ack = 1'b0;
        check("simul_valid", {31'd0, frame_valid}, 32'd1);
        check("simul_slot0", {16'd0, frame_data[0*16 +: 16]}, 32'h6600);
        check("simul_s_ready", {31'd0, s_ready}, 32'd1);
        check("simul_frames_done", {16'd0, frames_done}, 32'd6);
        ack();
        check("simul_drained", {31'd0, frame_valid}, 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
